// File: rtl/lsp_prev_compose_fsm.sv
// lsp_prev_compose_fsm
// Composes ten LSP values from the previous-frame predictor:
//   acc = L_mult(lsp_ele[j], fg_sum[j]); acc = L_mac(acc, freq_prev[k][j], fg[k][j]) k=0..3
//   lsp[j] = extract_h(acc)
// The multiply/accumulate arithmetic is external and combinational; this block
// sequences the memory reads, the operand steering and the scratch writes.
// Optional build macro: LSP_PREV_COMPOSE_ROUND_EN selects a rounding, saturating
// extract of the high half instead of plain truncation. Timing is identical either way.
module lsp_prev_compose_fsm (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  output logic        done,
  input  logic [10:0] lspEleAddr,
  input  logic [10:0] freqPrevAddr,
  input  logic [10:0] lspAddr,
  input  logic [11:0] fgAddr,
  input  logic [11:0] fgSumAddr,
  output logic [10:0] readAddr,
  input  logic [31:0] readIn,
  output logic [11:0] constantMemAddr,
  input  logic [31:0] constantMemIn,
  output logic [10:0] writeAddr,
  output logic [31:0] writeOut,
  output logic        writeEn,
  output logic [15:0] L_mult_a,
  output logic [15:0] L_mult_b,
  input  logic [31:0] L_mult_in,
  output logic [15:0] L_mac_a,
  output logic [15:0] L_mac_b,
  output logic [31:0] L_mac_c,
  input  logic [31:0] L_mac_in,
  output logic [15:0] add_a,
  output logic [15:0] add_b,
  input  logic [15:0] add_in
);

  typedef enum logic [3:0] {
    IDLE      = 4'd0,
    FETCH_ELE = 4'd1,
    WAIT_ELE  = 4'd2,
    MULT      = 4'd3,
    MAC_FETCH = 4'd4,
    MAC_WAIT  = 4'd5,
    MAC       = 4'd6,
    WRITE     = 4'd7,
    DONE      = 4'd8
  } state_t;

  state_t      state_r, state_nxt_s;
  logic [3:0]  j_r, j_nxt_s;
  logic [1:0]  k_r, k_nxt_s;
  logic [31:0] acc_r, acc_nxt_s;

  logic [10:0] ele_addr_s;
  logic [10:0] fp_addr_s;
  logic [10:0] lsp_addr_s;
  logic [11:0] fgsum_addr_s;
  logic [11:0] fg_addr_s;
  logic [15:0] result_s;

  // Only the low halves of the data words and no adder result are consumed.
  logic unused_inputs_s;
  assign unused_inputs_s = ^{add_in, readIn[31:16], constantMemIn[31:16]};

  // High half of the accumulator, optionally rounded with saturation at the top.
  function automatic logic [15:0] extract_h(input logic [31:0] acc);
    logic [31:0] rounded;
    rounded = acc + 32'h0000_8000;
`ifdef LSP_PREV_COMPOSE_ROUND_EN
    if ($signed(acc) >= $signed(32'h7FFF_8000)) begin
      extract_h = 16'h7FFF;
    end else begin
      extract_h = rounded[31:16];
    end
`else
    extract_h = acc[31:16] | (rounded[15:0] & 16'h0000);
`endif
  endfunction

  // Element / tap addresses; 16-word stride between predictor rows.
  always_comb begin
    ele_addr_s   = lspEleAddr + {7'd0, j_r};
    lsp_addr_s   = lspAddr + {7'd0, j_r};
    fp_addr_s    = freqPrevAddr + {5'd0, k_r, 4'd0} + {7'd0, j_r};
    fgsum_addr_s = fgSumAddr + {8'd0, j_r};
    fg_addr_s    = fgAddr + {6'd0, k_r, 4'd0} + {8'd0, j_r};
    result_s     = extract_h(acc_r);
  end

  // State, loop counters and accumulator; reset aborts any run in progress.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= IDLE;
      j_r     <= 4'd0;
      k_r     <= 2'd0;
      acc_r   <= 32'd0;
    end else begin
      state_r <= state_nxt_s;
      j_r     <= j_nxt_s;
      k_r     <= k_nxt_s;
      acc_r   <= acc_nxt_s;
    end
  end

  // Next-state decode and per-state output steering; unused outputs stay zero.
  always_comb begin
    state_nxt_s     = state_r;
    j_nxt_s         = j_r;
    k_nxt_s         = k_r;
    acc_nxt_s       = acc_r;
    done            = 1'b0;
    readAddr        = 11'd0;
    constantMemAddr = 12'd0;
    writeAddr       = 11'd0;
    writeOut        = 32'd0;
    writeEn         = 1'b0;
    L_mult_a        = 16'd0;
    L_mult_b        = 16'd0;
    L_mac_a         = 16'd0;
    L_mac_b         = 16'd0;
    L_mac_c         = 32'd0;
    add_a           = 16'd0;
    add_b           = 16'd0;
    case (state_r)
      IDLE: begin
        if (start) begin
          state_nxt_s = FETCH_ELE;
          j_nxt_s     = 4'd0;
          k_nxt_s     = 2'd0;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      FETCH_ELE: begin
        // Address is held through the wait cycle so the read data is still
        // for this element when it is consumed.
        readAddr        = ele_addr_s;
        constantMemAddr = fgsum_addr_s;
        state_nxt_s     = WAIT_ELE;
      end
      WAIT_ELE: begin
        readAddr        = ele_addr_s;
        constantMemAddr = fgsum_addr_s;
        state_nxt_s     = MULT;
      end
      MULT: begin
        L_mult_a    = readIn[15:0];
        L_mult_b    = constantMemIn[15:0];
        acc_nxt_s   = L_mult_in;
        state_nxt_s = MAC_FETCH;
      end
      MAC_FETCH: begin
        readAddr        = fp_addr_s;
        constantMemAddr = fg_addr_s;
        state_nxt_s     = MAC_WAIT;
      end
      MAC_WAIT: begin
        readAddr        = fp_addr_s;
        constantMemAddr = fg_addr_s;
        state_nxt_s     = MAC;
      end
      MAC: begin
        L_mac_a   = readIn[15:0];
        L_mac_b   = constantMemIn[15:0];
        L_mac_c   = acc_r;
        acc_nxt_s = L_mac_in;
        if (k_r == 2'd3) begin
          state_nxt_s = WRITE;
        end else begin
          k_nxt_s     = k_r + 2'd1;
          state_nxt_s = MAC_FETCH;
        end
      end
      WRITE: begin
        writeEn   = 1'b1;
        writeAddr = lsp_addr_s;
        writeOut  = {{16{result_s[15]}}, result_s};
        k_nxt_s   = 2'd0;
        if (j_r == 4'd9) begin
          state_nxt_s = DONE;
        end else begin
          j_nxt_s     = j_r + 4'd1;
          state_nxt_s = FETCH_ELE;
        end
      end
      DONE: begin
        done        = 1'b1;
        j_nxt_s     = 4'd0;
        state_nxt_s = IDLE;
      end
      default: begin
        state_nxt_s = IDLE;
        j_nxt_s     = 4'd0;
        k_nxt_s     = 2'd0;
        acc_nxt_s   = 32'd0;
      end
    endcase
  end

endmodule

// File: tb/tb_lsp_prev_compose_fsm.sv
// Bench for lsp_prev_compose_fsm: directed vector table, randomized runs against
// an arithmetic reference model, reset-abort and held-start sequences.
module tb_lsp_prev_compose_fsm;

  logic        clk = 1'b0;
  logic        reset, start, done;
  logic [10:0] lspEleAddr, freqPrevAddr, lspAddr;
  logic [11:0] fgAddr, fgSumAddr;
  logic [10:0] readAddr;
  logic [31:0] readIn;
  logic [11:0] constantMemAddr;
  logic [31:0] constantMemIn;
  logic [10:0] writeAddr;
  logic [31:0] writeOut;
  logic        writeEn;
  logic [15:0] L_mult_a, L_mult_b, L_mac_a, L_mac_b, add_a, add_b;
  logic [31:0] L_mult_in, L_mac_c, L_mac_in;
  logic [15:0] add_in;

  logic [31:0] scratch [2048];
  logic [31:0] cmem    [4096];
  logic [10:0] wq_addr [$];
  logic [31:0] wq_data [$];
  int          done_cnt = 0;
  logic [31:0] exp_data [10];

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    string       name;
    logic [15:0] ele, fgsum, fp, fg;
    logic [31:0] exp;
  } vec_t;
  vec_t vecs [4];

  always #5 clk = ~clk;

  lsp_prev_compose_fsm dut (
    .clk(clk), .reset(reset), .start(start), .done(done),
    .lspEleAddr(lspEleAddr), .freqPrevAddr(freqPrevAddr), .lspAddr(lspAddr),
    .fgAddr(fgAddr), .fgSumAddr(fgSumAddr),
    .readAddr(readAddr), .readIn(readIn),
    .constantMemAddr(constantMemAddr), .constantMemIn(constantMemIn),
    .writeAddr(writeAddr), .writeOut(writeOut), .writeEn(writeEn),
    .L_mult_a(L_mult_a), .L_mult_b(L_mult_b), .L_mult_in(L_mult_in),
    .L_mac_a(L_mac_a), .L_mac_b(L_mac_b), .L_mac_c(L_mac_c), .L_mac_in(L_mac_in),
    .add_a(add_a), .add_b(add_b), .add_in(add_in)
  );

  // Saturating fractional multiply / multiply-accumulate (environment + model).
  function automatic logic [31:0] f_mult(input logic [15:0] a, input logic [15:0] b);
    longint p;
    if (a == 16'h8000 && b == 16'h8000) return 32'h7FFF_FFFF;
    p = longint'($signed(a)) * longint'($signed(b)) * 64'sd2;
    return p[31:0];
  endfunction

  function automatic logic [31:0] f_mac(input logic [31:0] c, input logic [15:0] a, input logic [15:0] b);
    longint s;
    s = longint'($signed(c)) + longint'($signed(f_mult(a, b)));
    if (s > 64'sd2147483647) return 32'h7FFF_FFFF;
    if (s < -64'sd2147483648) return 32'h8000_0000;
    return s[31:0];
  endfunction

  function automatic logic [31:0] f_extract(input logic [31:0] acc);
    longint v, t;
    v = longint'($signed(acc));
`ifdef LSP_PREV_COMPOSE_ROUND_EN
    t = (v + 64'sd32768) >>> 16;
    if (t > 64'sd32767) t = 64'sd32767;
`else
    t = v >>> 16;
`endif
    return t[31:0];
  endfunction

  assign L_mult_in = f_mult(L_mult_a, L_mult_b);
  assign L_mac_in  = f_mac(L_mac_c, L_mac_a, L_mac_b);
  assign add_in    = 16'hA5A5;

  // Synchronous memories with one-cycle read latency, plus write/done monitor.
  always @(posedge clk) begin
    readIn        <= scratch[readAddr];
    constantMemIn <= cmem[constantMemAddr];
    if (writeEn) begin
      scratch[writeAddr] <= writeOut;
      wq_addr.push_back(writeAddr);
      wq_data.push_back(writeOut);
    end
    if (done) done_cnt++;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: straight from the composition formula over memory contents.
  task automatic compute_expected();
    logic [31:0] acc;
    for (int j = 0; j < 10; j++) begin
      acc = f_mult(scratch[11'(lspEleAddr + 11'(j))][15:0], cmem[12'(fgSumAddr + 12'(j))][15:0]);
      for (int k = 0; k < 4; k++)
        acc = f_mac(acc, scratch[11'(freqPrevAddr + 11'(16 * k + j))][15:0],
                    cmem[12'(fgAddr + 12'(16 * k + j))][15:0]);
      exp_data[j] = f_extract(acc);
    end
  endtask

  task automatic fill(input logic [15:0] ele, input logic [15:0] fgs, input logic [15:0] fp,
                      input logic [15:0] fg, input bit rnd);
    for (int j = 0; j < 10; j++) begin
      scratch[11'(lspEleAddr + 11'(j))] = {16'($urandom), rnd ? 16'($urandom) : ele};
      cmem[12'(fgSumAddr + 12'(j))]     = {16'($urandom), rnd ? 16'($urandom) : fgs};
      for (int k = 0; k < 4; k++) begin
        scratch[11'(freqPrevAddr + 11'(16 * k + j))] =
          {16'($urandom), rnd ? (($urandom % 6 == 0) ? 16'h8000 : 16'($urandom)) : fp};
        cmem[12'(fgAddr + 12'(16 * k + j))] =
          {16'($urandom), rnd ? (($urandom % 6 == 0) ? 16'h8000 : 16'($urandom)) : fg};
      end
      scratch[11'(lspAddr + 11'(j))] = 32'hDEAD_BEEF;
    end
  endtask

  task automatic run_full(input string tag);
    int n, bw, bd;
    bw = wq_addr.size();
    bd = done_cnt;
    @(negedge clk);
    start = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
      start = 1'b0;
    end while (!done && n < 400);
    check($sformatf("%s_done_cycle", tag), n, 161);
    @(negedge clk);
    check($sformatf("%s_done_pulse", tag), done_cnt - bd, 1);
    check($sformatf("%s_nwrites", tag), wq_addr.size() - bw, 10);
    for (int i = 0; i < 10; i++) begin
      if (bw + i < wq_addr.size()) begin
        check($sformatf("%s_waddr%0d", tag, i), 32'(wq_addr[bw + i]), 32'(lspAddr + 11'(i)));
        check($sformatf("%s_wdata%0d", tag, i), wq_data[bw + i], exp_data[i]);
      end
    end
  endtask

  // Reset at a given cycle of a run: everything must drop at once and stay quiet.
  task automatic reset_midrun(input string tag, input int at_n, input int nw, input logic exp_we);
    int n, bw, bd;
    bw = wq_addr.size();
    bd = done_cnt;
    @(negedge clk);
    start = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
      start = 1'b0;
    end while (n < at_n);
    check($sformatf("%s_we_before", tag), 32'(writeEn), 32'(exp_we));
    reset = 1'b0;
    #1;
    check($sformatf("%s_we_after", tag), 32'(writeEn), 32'd0);
    check($sformatf("%s_waddr_after", tag), 32'(writeAddr), 32'd0);
    check($sformatf("%s_wout_after", tag), writeOut, 32'd0);
    check($sformatf("%s_raddr_after", tag), 32'(readAddr), 32'd0);
    start = 1'b1;
    repeat (3) @(negedge clk);
    start = 1'b0;
    reset = 1'b1;
    repeat (200) @(negedge clk);
    check($sformatf("%s_nwrites", tag), wq_addr.size() - bw, nw);
    check($sformatf("%s_no_done", tag), done_cnt - bd, 0);
    for (int i = 0; i < 10; i++)
      check($sformatf("%s_lsp%0d", tag, i), scratch[11'(lspAddr + 11'(i))],
            (i < nw) ? exp_data[i] : 32'hDEAD_BEEF);
  endtask

  initial begin
    int n, first, second, bw, bd;
    reset = 1'b0;
    start = 1'b0;
    lspEleAddr = 11'h010; freqPrevAddr = 11'h100; lspAddr = 11'h300;
    fgAddr = 12'h040; fgSumAddr = 12'h800;
    for (int i = 0; i < 2048; i++) scratch[i] = 32'd0;
    for (int i = 0; i < 4096; i++) cmem[i] = 32'd0;

    vecs[0] = '{"zero",    16'h0000, 16'h0000, 16'h0000, 16'h0000, 32'h0000_0000};
    vecs[1] = '{"basic",   16'h1000, 16'h4000, 16'h2000, 16'h2000, 32'h0000_2800};
    vecs[2] = '{"sat",     16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF, 32'h0000_7FFF};
`ifdef LSP_PREV_COMPOSE_ROUND_EN
    vecs[3] = '{"round",   16'h0003, 16'h4000, 16'h0000, 16'h1234, 32'h0000_0002};
`else
    vecs[3] = '{"round",   16'h0003, 16'h4000, 16'h0000, 16'h1234, 32'h0000_0001};
`endif

    #12;
    check("rst_done", 32'(done), 32'd0);
    check("rst_we", 32'(writeEn), 32'd0);
    check("rst_wout", writeOut, 32'd0);
    check("rst_waddr", 32'(writeAddr), 32'd0);
    check("rst_raddr", 32'(readAddr), 32'd0);
    check("rst_caddr", 32'(constantMemAddr), 32'd0);
    check("rst_ops", {L_mult_a, L_mult_b}, 32'd0);
    check("rst_mac", {L_mac_a, L_mac_b} | L_mac_c, 32'd0);
    check("rst_add", {add_a, add_b}, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);

    // Directed table.
    for (int v = 0; v < 4; v++) begin
      fill(vecs[v].ele, vecs[v].fgsum, vecs[v].fp, vecs[v].fg, 1'b0);
      for (int j = 0; j < 10; j++) exp_data[j] = vecs[v].exp;
      run_full(vecs[v].name);
    end

    // Randomized runs against the model.
    for (int r = 0; r < 6; r++) begin
      lspEleAddr   = 11'($urandom_range(0, 200));
      freqPrevAddr = 11'($urandom_range(256, 700));
      lspAddr      = 11'($urandom_range(800, 1500));
      fgAddr       = 12'($urandom_range(0, 1500));
      fgSumAddr    = 12'($urandom_range(2000, 4000));
      fill(16'd0, 16'd0, 16'd0, 16'd0, 1'b1);
      compute_expected();
      run_full($sformatf("rnd%0d", r));
    end

    // Reset during element 4 MAC, then during element 2 WRITE; then a clean restart.
    fill(vecs[1].ele, vecs[1].fgsum, vecs[1].fp, vecs[1].fg, 1'b0);
    compute_expected();
    reset_midrun("rst_mac4", 70, 4, 1'b0);
    fill(vecs[1].ele, vecs[1].fgsum, vecs[1].fp, vecs[1].fg, 1'b0);
    reset_midrun("rst_wr2", 48, 2, 1'b1);
    run_full("restart");

    // Start held high through a whole run.
    fill(16'h0000, 16'h0000, 16'h0000, 16'h0000, 1'b1);
    compute_expected();
    bw = wq_addr.size();
    bd = done_cnt;
    @(negedge clk);
    start = 1'b1;
    n = 0; first = 0; second = 0;
    while (second == 0 && n < 800) begin
      @(negedge clk);
      n++;
      if (done) begin
        if (first == 0) first = n;
        else second = n;
      end
    end
    start = 1'b0;
    check("hold_first_done", first, 161);
    check("hold_second_done", second, 323);
    repeat (20) @(negedge clk);
    check("hold_nwrites", wq_addr.size() - bw, 20);
    check("hold_ndone", done_cnt - bd, 2);
    for (int i = 0; i < 20; i++)
      if (bw + i < wq_addr.size()) begin
        check($sformatf("hold_waddr%0d", i), 32'(wq_addr[bw + i]), 32'(lspAddr + 11'(i % 10)));
        check($sformatf("hold_wdata%0d", i), wq_data[bw + i], exp_data[i % 10]);
      end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
